// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants for the instruction fetch path.
//   instr_size    : width of an instruction word
//   nop_instr     : addi x0,x0,0, shown to decode whenever no real instruction is available
//   fetch_state_t : fetch FSM states
package instr_fetch_queue_pkg;
    localparam int instr_size = 32;
    localparam logic [instr_size-1:0] nop_instr = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} pairs feeding the fetch output register.
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_clear              : drop all entries (flush)
//   i_push, i_push_pc/instr : write one entry at the tail
//   i_pop                : remove the head entry (caller only pops when non-empty)
//   o_head_pc/instr      : head entry
//   o_count              : number of valid entries, 0..DEPTH
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [31:0]           i_push_pc,
    input  logic [instr_size-1:0] i_push_instr,
    input  logic                  i_pop,
    output logic [31:0]           o_head_pc,
    output logic [instr_size-1:0] o_head_instr,
    output logic [CW-1:0]         o_count
);
    logic [31:0]           r_pc    [DEPTH];
    logic [instr_size-1:0] r_instr [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    // Storage needs no reset; validity is tracked by the pointers/count.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_pc[r_wptr]    <= i_push_pc;
            r_instr[r_wptr] <= i_push_instr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_pc    = r_pc[r_rptr];
    assign o_head_instr = r_instr[r_rptr];
    assign o_count      = r_count;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: issues sequential fetches, buffers returned words and
// presents one instruction per cycle to the control unit.
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req/addr/ready               : request channel to instruction memory
//   imem_rvalid/rdata                 : in-order read responses
//   stall                             : decode holds the current instruction
//   chng2nop, redirect_pc             : flush wrong-path work and refetch from redirect_pc
//   instr_out, pc_out, instr_valid    : registered instruction to decode
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [31:0]           imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [instr_size-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  chng2nop,
    input  logic [31:0]           redirect_pc,
    output logic [instr_size-1:0] instr_out,
    output logic [31:0]           pc_out,
    output logic                  instr_valid
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          r_state, w_state_nxt;
    logic [31:0]           r_fetch_pc;
    logic [31:0]           r_resp_pc;      // PC of the next response that will be kept
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_drop_cnt;
    logic [instr_size-1:0] r_instr_out;
    logic [31:0]           r_pc_out;
    logic                  r_instr_valid;

    logic [CW-1:0]         w_count;
    logic [31:0]           w_head_pc;
    logic [instr_size-1:0] w_head_instr;
    logic                  w_credit, w_req, w_issue;
    logic                  w_resp_ok, w_bypass, w_push, w_pop, w_empty;
    logic [CW-1:0]         w_drop_nxt;

    // Credit covers buffered plus in-flight words, so every response has a slot.
    assign w_credit  = ({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
    assign w_issue   = w_req && imem_ready;
    assign w_empty   = (w_count == '0);
    // A response in the flush cycle is wrong-path and never kept.
    assign w_resp_ok = imem_rvalid && (r_drop_cnt == '0) && !chng2nop;
    // Empty queue and decode ready: the response goes straight to the output
    // register, giving one-cycle response-to-decode latency.
    assign w_bypass  = w_resp_ok && w_empty && !stall;
    assign w_push    = w_resp_ok && !w_bypass;
    assign w_pop     = !chng2nop && !stall && !w_empty;

    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (chng2nop)
            w_drop_nxt = r_outstanding - CW'(imem_rvalid);
        else if (imem_rvalid && (r_drop_cnt != '0))
            w_drop_nxt = r_drop_cnt - CW'(1);
    end

    // The request is gated by rst directly so the first cycle out of reset
    // already fetches RESET_PC while the state register is leaving RESET.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            RESET:        w_state_nxt = FETCH;
            FETCH, DRAIN: w_state_nxt = (w_drop_nxt != '0) ? DRAIN : FETCH;
            default:      w_state_nxt = FETCH;
        endcase
        if (!rst && !chng2nop && w_credit) w_req = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RESET;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(imem_rvalid);
            r_drop_cnt    <= w_drop_nxt;
            if (chng2nop) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
            end else begin
                if (w_issue)   r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_resp_ok) r_resp_pc  <= r_resp_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || chng2nop) begin
            r_instr_out   <= nop_instr;
            r_instr_valid <= 1'b0;
            if (rst) r_pc_out <= '0;
        end else if (!stall) begin
            if (w_pop) begin
                r_instr_out   <= w_head_instr;
                r_pc_out      <= w_head_pc;
                r_instr_valid <= 1'b1;
            end else if (w_bypass) begin
                r_instr_out   <= imem_rdata;
                r_pc_out      <= r_resp_pc;
                r_instr_valid <= 1'b1;
            end else begin
                r_instr_out   <= nop_instr;
                r_instr_valid <= 1'b0;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clear      (chng2nop),
        .i_push       (w_push),
        .i_push_pc    (r_resp_pc),
        .i_push_instr (imem_rdata),
        .i_pop        (w_pop),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_count      (w_count)
    );

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign instr_out   = r_instr_out;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_instr_valid;
endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] K     = 32'h5A00_0000;   // memory returns addr ^ K
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, chng2nop;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out, pc_out;
    logic        instr_valid;

    // second instance exercising address wrap from RESET_PC
    logic        req2, rv2;
    logic [31:0] addr2, rd2, instr2, pc2;
    logic        valid2;
    logic        s_req2;
    logic [31:0] s_addr2;

    int n_chk = 0;
    int n_err = 0;

    typedef struct { int unsigned due; logic [31:0] addr; } pend_t;
    pend_t       pend[$];
    logic [31:0] expq[$];
    int unsigned cyc = 0;
    int unsigned lat;
    logic        s_iss;
    logic [31:0] s_addr;
    logic [31:0] exp_iss;
    logic        loaded = 1'b0;
    logic        hold   = 1'b0;
    logic        have_prev = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    logic        prev_valid;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .chng2nop(chng2nop), .redirect_pc(redirect_pc),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid)
    );

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
        .imem_ready(1'b1), .imem_rvalid(rv2), .imem_rdata(rd2),
        .stall(1'b0), .chng2nop(1'b0), .redirect_pc(32'h0),
        .instr_out(instr2), .pc_out(pc2), .instr_valid(valid2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model + scoreboard feed: sample the request at the edge, respond #1 later.
    always @(posedge clk) begin
        s_iss  = imem_req && imem_ready && !rst;
        s_addr = imem_addr;
        if (rst) begin
            pend.delete();
            expq.delete();
            exp_iss = 32'h0;
            loaded  = 1'b0;
            hold    = 1'b0;
        end else begin
            loaded = !stall || chng2nop;
            hold   = stall && !chng2nop;
            if (chng2nop) begin
                expq.delete();
                exp_iss = redirect_pc;
                if (s_iss) chk("issue_in_flush", 32'(s_iss), 32'h0);
            end else if (s_iss) begin
                chk("issue_addr", s_addr, exp_iss);
                exp_iss = exp_iss + 32'd4;
                expq.push_back(s_addr);
            end
            if (s_iss) begin
                pend.push_back('{due: cyc + lat, addr: s_addr});
                chk("mem_outstanding_le_depth", 32'(pend.size() <= DEPTH), 32'h1);
            end
        end
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ K;
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // 1-cycle always-ready memory for the wrap instance
    always @(posedge clk) begin
        s_req2  = req2 && !rst;
        s_addr2 = addr2;
        #1;
        rv2 = s_req2;
        rd2 = s_addr2 ^ K;
    end

    // Monitor: every freshly loaded valid output must match the scoreboard head;
    // outputs must hold through a stall.
    always @(negedge clk) begin
        logic [31:0] e;
        if (loaded && instr_valid) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL out_unexpected: got pc %h expected no output", pc_out);
            end else begin
                e = expq.pop_front();
                chk("out_pc", pc_out, e);
                chk("out_instr", instr_out, e ^ K);
            end
        end
        if (hold && have_prev) begin
            chk("hold_pc", pc_out, prev_pc);
            chk("hold_instr", instr_out, prev_instr);
            chk("hold_valid", 32'(instr_valid), 32'(prev_valid));
        end
        prev_pc    = pc_out;
        prev_instr = instr_out;
        prev_valid = instr_valid;
        have_prev  = !rst;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] spc;
        rst = 1'b1; stall = 1'b0; chng2nop = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        rv2 = 1'b0; rd2 = 32'h0; lat = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_addr2", addr2, 32'hFFFF_FFF8);

        // cycle 0
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("c0_req", 32'(imem_req), 32'h1);
        chk("c0_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("c1_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("c2_pc", pc_out, 32'h0);
        chk("c2_valid", 32'(instr_valid), 32'h1);
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        chk("wrap_instr0", instr2, 32'hFFFF_FFF8 ^ K);
        @(negedge clk);
        chk("c3_pc", pc_out, 32'h4);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("c4_pc", pc_out, 32'h8);
        chk("wrap_pc2", pc2, 32'h0000_0000);
        chk("wrap_valid2", 32'(valid2), 32'h1);
        cycles(6);

        // 3-cycle stall mid-stream
        stall = 1'b1;
        @(negedge clk); spc = pc_out;
        cycles(3);
        chk("stall_pc_const", pc_out, spc);
        stall = 1'b0;
        cycles(6);

        // fill the queue under stall, then memory not ready for 10 cycles
        stall = 1'b1;
        cycles(8);
        @(negedge clk);
        chk("full_req_low", 32'(imem_req), 32'h0);
        @(posedge clk); #1 imem_ready = 1'b0;
        cycles(10);
        @(negedge clk);
        chk("full_req_still_low", 32'(imem_req), 32'h0);
        @(posedge clk); #1 stall = 1'b0;
        cycles(3);
        imem_ready = 1'b1;
        cycles(6);

        // flush with three requests outstanding at latency 3
        lat = 3;
        cycles(10);
        chng2nop = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        chk("flush_no_req", 32'(imem_req), 32'h0);
        @(posedge clk); #1 chng2nop = 1'b0;
        @(negedge clk);
        chk("f1_valid", 32'(instr_valid), 32'h0);
        chk("f1_nop", instr_out, NOP);
        chk("f1_req", 32'(imem_req), 32'h1);
        chk("f1_addr", imem_addr, 32'h100);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk("drain_valid_low", 32'(instr_valid), 32'h0);
        end
        @(negedge clk);
        chk("f5_valid", 32'(instr_valid), 32'h1);
        chk("f5_pc", pc_out, 32'h100);
        @(negedge clk);
        chk("f6_pc", pc_out, 32'h104);
        cycles(6);

        // flush coinciding with a response and stall
        stall = 1'b1; chng2nop = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        chk("fs_rvalid_present", 32'(imem_rvalid), 32'h1);
        @(posedge clk); #1 chng2nop = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("fs1_valid", 32'(instr_valid), 32'h0);
        chk("fs1_nop", instr_out, NOP);
        chk("fs1_addr", imem_addr, 32'h200);
        repeat (4) @(negedge clk);
        chk("fs5_pc", pc_out, 32'h200);
        chk("fs5_valid", 32'(instr_valid), 32'h1);

        // stop issuing and let everything drain; nothing may be lost
        lat = 1;
        cycles(8);
        imem_ready = 1'b0;
        cycles(20);
        chk("drain_sb_empty", 32'(expq.size()), 32'h0);
        chk("drain_mem_empty", 32'(pend.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
